status_flag_unit: RTL and testbench
===================================

# status_flag_unit

Producer side of the NZCV status path. Computes N/Z/C/V from the execute-stage operation and operands, holds them in a one-entry staging register, and commits them to the architectural status register. Its `sr` output is the 4-bit NZCV word consumed by the condition checker in the decode stage. It also provides a forwarded view and a hazard flag, so decode can evaluate conditions on flags that are still in flight.

## Interface
Parameters:
- `W`, 32, operand/result width.

Ports (clock and reset first):
- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `rst_n`  in  1  reset, synchronous, active-low.
- `valid`  in  1  execute-stage instruction present this cycle.
- `s_en`  in  1  instruction updates flags (S bit, or CMP/TST).
- `exe_cmd`  in  4  ALU command (package constants).
- `op_a`  in  W  first ALU operand.
- `op_b`  in  W  second ALU operand.
- `freeze`  in  1  pipeline stall; hold all state.
- `flush`  in  1  branch taken; cancel the staged, uncommitted update.
- `sr`  out  4  committed NZCV (bit3 N, bit2 Z, bit1 C, bit0 V).
- `sr_fwd`  out  4  staged NZCV if the staging entry is valid, else `sr`.
- `carry_out`  out  1  carry to the ALU for ADC/SBC; equals `sr_fwd[1]`.
- `sr_hazard`  out  1  high while the staging entry is valid.

## Operation
- Result and flags are computed combinationally from `exe_cmd`, `op_a`, `op_b` and `carry_out`:
  - MOV = b; MVN = ~b.
  - ADD = a+b; ADC = a+b+C.
  - SUB = a-b; SBC = a-b-~C.
  - AND, ORR, EOR as named.
  - CMP behaves as SUB; TST behaves as AND.
- Flag rules:
  - N = result[W-1].
  - Z = (result == 0).
  - Arithmetic ops: C is the unsigned carry-out of a (W+1)-bit sum. For SUB/SBC/CMP, C = NOT borrow.
  - Arithmetic ops: V = signed overflow, i.e. operand signs agree and the result sign differs (subtract uses ~b).
  - Logic and move ops: C and V keep their `sr_fwd` values.
  - Unknown command: no flag update, treated as `s_en = 0`.
- Staging entry `{stg_v, stg_sr}`:
  - Loaded when `valid & s_en & ~freeze & ~flush`.
  - Otherwise cleared, unless `freeze` is high.
- Commit: when `stg_v & ~freeze`, `sr <= stg_sr` on the same edge as any new load. Back-to-back S instructions therefore pipeline with no bubble.
- `flush`:
  - Clears `stg_v` without committing.
  - Blocks the current load.
  - Leaves `sr` unchanged.
- `freeze` takes precedence over load and commit; `flush` takes precedence over `freeze`.

## Timing
- Reset (`rst_n = 0` at an edge): `sr = 4'b0000`, `stg_v = 0`, `stg_sr = 0`. Therefore `sr_fwd = 0`, `carry_out = 0`, `sr_hazard = 0`.
- Reset wins over every other input, including mid-flush and mid-freeze.
- Latency:
  - Flags visible on `sr_fwd` 1 cycle after the load edge.
  - Flags visible on `sr` 2 cycles after the load edge, absent freeze.
- Simultaneous load and commit in one cycle: commit takes the old `stg_sr`; the entry takes the new value.
- `flush` together with a pending entry: the entry is discarded and `sr` is unchanged.
- `freeze` held N cycles: `sr`, `stg_*` and all outputs are stable for N cycles.
- Outputs are driven only by registers and a 2:1 mux; there is no combinational path from operands to `sr`.

## Structure
- Shared package `arm_pkg`:
  - `exe_cmd` localparams: MOV=0001, MVN=1001, ADD=0010, ADC=0011, SUB=0100, SBC=0101, AND=0110, ORR=0111, EOR=1000.
  - NZCV bit indices N_BIT=3, Z_BIT=2, C_BIT=1, V_BIT=0.
- One sub-module, `flag_calc`: combinational result and NZCV generation. The top level holds the staging and commit registers and the forwarding mux.

## Test plan
- Reset then idle: `sr = 0000`, `sr_hazard = 0` for 5 cycles.
- ADD with `s_en`, a=0x7FFFFFFF, b=1:
  - `sr_fwd = 1001` (N, V) next cycle, with `sr_hazard = 1`.
  - `sr = 1001` the cycle after.
- CMP a=5, b=5, then back-to-back SUB a=0, b=1:
  - `sr` sequence is 0110, then 1000.
  - No bubble between the two updates.
- ADC a=0xFFFFFFFF, b=0, with committed C=1:
  - Result 0.
  - `sr = 0110` (Z and C set; V clear because operand signs differ).
- `flush` asserted one cycle after an S-instruction load: `sr` keeps its prior value and `sr_hazard` drops.
- `freeze` held 3 cycles with an entry pending:
  - `sr` and `sr_fwd` are stable throughout.
  - Commit occurs on the first unfrozen edge.

Source files
------------

// File: rtl/arm_pkg.sv
// rtl/arm_pkg.sv - shared ALU command encodings and NZCV bit positions
package arm_pkg;

    // Execute-stage ALU commands. CMP issues as CMD_SUB and TST as CMD_AND;
    // decode raises s_en for them without writing a destination register.
    localparam logic [3:0] CMD_MOV = 4'b0001;
    localparam logic [3:0] CMD_MVN = 4'b1001;
    localparam logic [3:0] CMD_ADD = 4'b0010;
    localparam logic [3:0] CMD_ADC = 4'b0011;
    localparam logic [3:0] CMD_SUB = 4'b0100;
    localparam logic [3:0] CMD_SBC = 4'b0101;
    localparam logic [3:0] CMD_AND = 4'b0110;
    localparam logic [3:0] CMD_ORR = 4'b0111;
    localparam logic [3:0] CMD_EOR = 4'b1000;

    // Bit positions inside the 4-bit NZCV word.
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    // Commands outside the table never touch the flags.
    function automatic logic is_known_cmd(input logic [3:0] cmd);
        case (cmd)
            CMD_MOV, CMD_MVN, CMD_ADD, CMD_ADC, CMD_SUB,
            CMD_SBC, CMD_AND, CMD_ORR, CMD_EOR: is_known_cmd = 1'b1;
            default:                            is_known_cmd = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/flag_calc.sv
// rtl/flag_calc.sv - combinational ALU result and NZCV generation
module flag_calc
    import arm_pkg::*;
#(
    parameter int W = 32
) (
    input  logic [3:0]   cmd_i,
    input  logic [W-1:0] op_a_i,
    input  logic [W-1:0] op_b_i,
    input  logic         c_fwd_i,
    input  logic         v_fwd_i,
    output logic [3:0]   nzcv_o,
    output logic         known_o
);

    logic [W-1:0] result;
    logic [W-1:0] b_eff;
    logic [W:0]   sum;
    logic         is_arith;
    logic         is_sub;
    logic         use_carry;
    logic         cin;

    // Decode the command into adder controls; logic/move ops produce their result directly.
    always_comb begin
        is_arith  = 1'b0;
        is_sub    = 1'b0;
        use_carry = 1'b0;
        result    = '0;
        case (cmd_i)
            CMD_ADD: is_arith = 1'b1;
            CMD_ADC: begin is_arith = 1'b1; use_carry = 1'b1; end
            CMD_SUB: begin is_arith = 1'b1; is_sub = 1'b1; end
            CMD_SBC: begin is_arith = 1'b1; is_sub = 1'b1; use_carry = 1'b1; end
            CMD_MOV: result = op_b_i;
            CMD_MVN: result = ~op_b_i;
            CMD_AND: result = op_a_i & op_b_i;
            CMD_ORR: result = op_a_i | op_b_i;
            CMD_EOR: result = op_a_i ^ op_b_i;
            default: result = '0;
        endcase
    end

    // Subtract is a + ~b + 1 (SUB) or a + ~b + C (SBC), so the carry-out is NOT borrow.
    assign b_eff = is_sub ? ~op_b_i : op_b_i;
    assign cin   = use_carry ? c_fwd_i : is_sub;
    assign sum   = {1'b0, op_a_i} + {1'b0, b_eff} + {{W{1'b0}}, cin};

    logic [W-1:0] res_final;
    assign res_final = is_arith ? sum[W-1:0] : result;

    // N/Z always follow the result; C/V only change for arithmetic commands.
    always_comb begin
        nzcv_o        = 4'b0000;
        nzcv_o[N_BIT] = res_final[W-1];
        nzcv_o[Z_BIT] = (res_final == '0);
        nzcv_o[C_BIT] = is_arith ? sum[W] : c_fwd_i;
        nzcv_o[V_BIT] = is_arith ? ((op_a_i[W-1] == b_eff[W-1]) && (sum[W-1] != op_a_i[W-1]))
                                 : v_fwd_i;
    end

    assign known_o = is_known_cmd(cmd_i);

endmodule

// File: rtl/status_flag_unit.sv
// rtl/status_flag_unit.sv - NZCV staging, commit and forwarding
module status_flag_unit
    import arm_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         valid,
    input  logic         s_en,
    input  logic [3:0]   exe_cmd,
    input  logic [W-1:0] op_a,
    input  logic [W-1:0] op_b,
    input  logic         freeze,
    input  logic         flush,
    output logic [3:0]   sr,
    output logic [3:0]   sr_fwd,
    output logic         carry_out,
    output logic         sr_hazard
);

    logic       stg_v_q, stg_v_d;
    logic [3:0] stg_sr_q, stg_sr_d;
    logic [3:0] sr_q, sr_d;
    logic [3:0] new_nzcv;
    logic       cmd_known;
    logic       load;
    logic       commit;

    // Flags are computed against the forwarded view so ADC/SBC and
    // flag-preserving ops see an in-flight update without a bubble.
    flag_calc #(.W(W)) u_flag_calc (
        .cmd_i   (exe_cmd),
        .op_a_i  (op_a),
        .op_b_i  (op_b),
        .c_fwd_i (sr_fwd[C_BIT]),
        .v_fwd_i (sr_fwd[V_BIT]),
        .nzcv_o  (new_nzcv),
        .known_o (cmd_known)
    );

    assign load   = valid & s_en & cmd_known & ~freeze & ~flush;
    assign commit = stg_v_q & ~freeze & ~flush;

    // Next state: flush discards the entry, freeze holds, else load or clear.
    always_comb begin
        stg_v_d  = 1'b0;
        stg_sr_d = 4'b0000;
        sr_d     = sr_q;
        if (flush) begin
            stg_v_d  = 1'b0;
            stg_sr_d = 4'b0000;
        end else if (freeze) begin
            stg_v_d  = stg_v_q;
            stg_sr_d = stg_sr_q;
        end else if (load) begin
            stg_v_d  = 1'b1;
            stg_sr_d = new_nzcv;
        end
        if (commit) begin
            sr_d = stg_sr_q;
        end
    end

    // Staging entry and architectural status register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stg_v_q  <= 1'b0;
            stg_sr_q <= 4'b0000;
            sr_q     <= 4'b0000;
        end else begin
            stg_v_q  <= stg_v_d;
            stg_sr_q <= stg_sr_d;
            sr_q     <= sr_d;
        end
    end

    assign sr        = sr_q;
    assign sr_fwd    = stg_v_q ? stg_sr_q : sr_q;
    assign carry_out = sr_fwd[C_BIT];
    assign sr_hazard = stg_v_q;

endmodule

// File: tb/tb_status_flag_unit.sv
// tb/tb_status_flag_unit.sv - directed self-checking bench for status_flag_unit
module tb_status_flag_unit;
    import arm_pkg::*;

    localparam int W = 32;

    logic         clk;
    logic         rst_n;
    logic         valid;
    logic         s_en;
    logic [3:0]   exe_cmd;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         freeze;
    logic         flush;
    logic [3:0]   sr;
    logic [3:0]   sr_fwd;
    logic         carry_out;
    logic         sr_hazard;

    int n_checks;
    int n_fail;

    status_flag_unit #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .valid     (valid),
        .s_en      (s_en),
        .exe_cmd   (exe_cmd),
        .op_a      (op_a),
        .op_b      (op_b),
        .freeze    (freeze),
        .flush     (flush),
        .sr        (sr),
        .sr_fwd    (sr_fwd),
        .carry_out (carry_out),
        .sr_hazard (sr_hazard)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic drive(input logic v, input logic s, input logic [3:0] cmd,
                         input logic [W-1:0] a, input logic [W-1:0] b);
        valid   = v;
        s_en    = s;
        exe_cmd = cmd;
        op_a    = a;
        op_b    = b;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 4'b0000, '0, '0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        freeze = 1'b0;
        flush = 1'b0;
        drive(1'b1, 1'b1, CMD_ADD, 32'h7FFF_FFFF, 32'h1);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        idle();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_checks++;
            if (sr !== 4'b0000 || sr_hazard !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: sr=%b hazard=%b, want 0000/0", i, sr, sr_hazard);
            end
        end
        n_checks++;
        if (sr_fwd !== 4'b0000 || carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_fwd: sr_fwd=%b carry=%b, want 0000/0", sr_fwd, carry_out);
        end
    endtask

    task automatic test_add_overflow();
        drive(1'b1, 1'b1, CMD_ADD, 32'h7FFF_FFFF, 32'h0000_0001);
        @(negedge clk);
        idle();
        n_checks++;
        if (sr_fwd !== 4'b1001 || sr_hazard !== 1'b1 || sr !== 4'b0000) begin
            n_fail++;
            $display("FAIL add_fwd: sr_fwd=%b hazard=%b sr=%b, want 1001/1/0000", sr_fwd, sr_hazard, sr);
        end
        @(negedge clk);
        n_checks++;
        if (sr !== 4'b1001 || sr_hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL add_commit: sr=%b hazard=%b, want 1001/0", sr, sr_hazard);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, CMD_SUB, 32'd5, 32'd5);
        @(negedge clk);
        drive(1'b1, 1'b1, CMD_SUB, 32'd0, 32'd1);
        n_checks++;
        if (sr_fwd !== 4'b0110) begin
            n_fail++;
            $display("FAIL b2b_cmp_fwd: sr_fwd=%b, want 0110", sr_fwd);
        end
        @(negedge clk);
        idle();
        n_checks++;
        if (sr !== 4'b0110 || sr_fwd !== 4'b1000 || sr_hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: sr=%b sr_fwd=%b hazard=%b, want 0110/1000/1", sr, sr_fwd, sr_hazard);
        end
        @(negedge clk);
        n_checks++;
        if (sr !== 4'b1000 || sr_hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: sr=%b hazard=%b, want 1000/0", sr, sr_hazard);
        end
    endtask

    task automatic test_adc_carry();
        drive(1'b1, 1'b1, CMD_SUB, 32'd5, 32'd5);
        @(negedge clk);
        idle();
        @(negedge clk);
        n_checks++;
        if (sr !== 4'b0110 || carry_out !== 1'b1) begin
            n_fail++;
            $display("FAIL adc_setup: sr=%b carry=%b, want 0110/1", sr, carry_out);
        end
        drive(1'b1, 1'b1, CMD_ADC, 32'hFFFF_FFFF, 32'h0);
        @(negedge clk);
        idle();
        @(negedge clk);
        n_checks++;
        if (sr !== 4'b0110) begin
            n_fail++;
            $display("FAIL adc_result: sr=%b, want 0110", sr);
        end
    endtask

    task automatic test_logic_preserve();
        // MOV keeps C=1 and V=0 from the committed flags.
        drive(1'b1, 1'b1, CMD_MOV, 32'h0, 32'h8000_0000);
        @(negedge clk);
        idle();
        @(negedge clk);
        n_checks++;
        if (sr !== 4'b1010) begin
            n_fail++;
            $display("FAIL mov_flags: sr=%b, want 1010", sr);
        end
        // SBC 5-3 with C=1: result 2, no borrow.
        drive(1'b1, 1'b1, CMD_SBC, 32'd5, 32'd3);
        @(negedge clk);
        idle();
        @(negedge clk);
        n_checks++;
        if (sr !== 4'b0010) begin
            n_fail++;
            $display("FAIL sbc_flags: sr=%b, want 0010", sr);
        end
        // Unknown command with s_en must not stage anything.
        drive(1'b1, 1'b1, 4'b1111, 32'd0, 32'd0);
        @(negedge clk);
        idle();
        n_checks++;
        if (sr_hazard !== 1'b0 || sr_fwd !== 4'b0010) begin
            n_fail++;
            $display("FAIL unknown_cmd: hazard=%b sr_fwd=%b, want 0/0010", sr_hazard, sr_fwd);
        end
    endtask

    task automatic test_flush();
        drive(1'b1, 1'b1, CMD_ADD, 32'h7FFF_FFFF, 32'h1);
        @(negedge clk);
        idle();
        flush = 1'b1;
        n_checks++;
        if (sr_hazard !== 1'b1) begin
            n_fail++;
            $display("FAIL flush_pre: hazard=%b, want 1", sr_hazard);
        end
        @(negedge clk);
        n_checks++;
        if (sr !== 4'b0010 || sr_hazard !== 1'b0 || sr_fwd !== 4'b0010) begin
            n_fail++;
            $display("FAIL flush_discard: sr=%b hazard=%b sr_fwd=%b, want 0010/0/0010", sr, sr_hazard, sr_fwd);
        end
        // Flush coincident with a load blocks the load.
        drive(1'b1, 1'b1, CMD_ADD, 32'h0, 32'h0);
        @(negedge clk);
        flush = 1'b0;
        idle();
        n_checks++;
        if (sr_hazard !== 1'b0 || sr !== 4'b0010) begin
            n_fail++;
            $display("FAIL flush_block: hazard=%b sr=%b, want 0/0010", sr_hazard, sr);
        end
    endtask

    task automatic test_freeze();
        drive(1'b1, 1'b1, CMD_ADD, 32'h0, 32'h0);
        @(negedge clk);
        freeze = 1'b1;
        drive(1'b1, 1'b1, CMD_MVN, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (sr !== 4'b0010 || sr_fwd !== 4'b0100 || sr_hazard !== 1'b1) begin
                n_fail++;
                $display("FAIL freeze_hold cycle %0d: sr=%b sr_fwd=%b hazard=%b, want 0010/0100/1",
                         i, sr, sr_fwd, sr_hazard);
            end
        end
        freeze = 1'b0;
        idle();
        @(negedge clk);
        n_checks++;
        if (sr !== 4'b0100 || sr_hazard !== 1'b0) begin
            n_fail++;
            $display("FAIL freeze_commit: sr=%b hazard=%b, want 0100/0", sr, sr_hazard);
        end
    endtask

    task automatic test_reset_mid_freeze();
        drive(1'b1, 1'b1, CMD_ADD, 32'h7FFF_FFFF, 32'h1);
        @(negedge clk);
        freeze = 1'b1;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        freeze = 1'b0;
        idle();
        n_checks++;
        if (sr !== 4'b0000 || sr_fwd !== 4'b0000 || sr_hazard !== 1'b0 || carry_out !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_freeze: sr=%b sr_fwd=%b hazard=%b carry=%b, want all zero",
                     sr, sr_fwd, sr_hazard, carry_out);
        end
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        freeze   = 1'b0;
        flush    = 1'b0;
        idle();
        @(negedge clk);
        test_reset();
        test_add_overflow();
        test_back_to_back();
        test_adc_carry();
        test_logic_preserve();
        test_flush();
        test_freeze();
        test_reset_mid_freeze();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
